// File: rtl/ro_frame_sched.sv
// ro_frame_sched: sticky event capture and time-multiplexed I/Q readout, one channel per slot after a header slot.
// Define RO_PARITY_EN to append a parity slot carrying the XOR of all values emitted in the frame.
module ro_frame_sched #(
  parameter int N_CH   = 16,
  parameter int SLOT_W = 4,
  parameter int OVF_W  = 8
) (
  input  logic              clk_master,
  input  logic              rstb,
  input  logic              ro_en,
  input  logic [N_CH-1:0]   eve_I,
  input  logic [N_CH-1:0]   pol_I,
  input  logic [N_CH-1:0]   eve_Q,
  input  logic [N_CH-1:0]   pol_Q,
  output logic [SLOT_W-1:0] slot_gray,
  output logic              frame_sync,
  output logic [1:0]        read_out_I,
  output logic [1:0]        read_out_Q,
  output logic [OVF_W-1:0]  ovf_cnt,
  output logic              busy
);
  localparam int HW = $clog2(4 * N_CH + 1);
  localparam int SW = ((OVF_W > HW) ? OVF_W : HW) + 1;
  typedef enum logic [1:0] {IDLE, HEADER, SCAN, PARITY} state_t;
  state_t              r_state, w_nxt_state, w_end_st;
  logic [SLOT_W-1:0]   r_k, w_nxt_k;
  logic [N_CH-1:0]     r_pe_I, r_pp_I, r_pe_Q, r_pp_Q, w_clr;
  logic [SLOT_W-1:0]   r_slot_gray, w_o_gray;
  logic                r_frame_sync, w_o_fs, r_busy, w_o_busy, w_last;
  logic [1:0]          r_ro_I, r_ro_Q, w_o_I, w_o_Q, w_rd_I, w_rd_Q;
  logic [1:0]          r_par_I, r_par_Q, w_par_I, w_par_Q;
  logic [OVF_W-1:0]    r_ovf, w_ovf;
  logic [HW-1:0]       w_hits;
  logic [SW-1:0]       w_sum;
  assign w_last = (r_k == SLOT_W'(N_CH - 1));
`ifdef RO_PARITY_EN
  assign w_end_st = PARITY;
`else
  assign w_end_st = ro_en ? HEADER : IDLE;
`endif
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      r_state <= IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_k     <= w_nxt_k;
    end
  end
  always_comb begin
    w_nxt_state = r_state;
    unique case (r_state)
      IDLE:    w_nxt_state = ro_en ? HEADER : IDLE;
      HEADER:  w_nxt_state = SCAN;
      SCAN:    w_nxt_state = w_last ? w_end_st : SCAN;
      default: w_nxt_state = ro_en ? HEADER : IDLE;
    endcase
  end
  assign w_nxt_k = (r_state == SCAN) ? r_k + 1'b1 : '0;
  // Only the channel whose slot is being entered is cleared; a same-edge input keeps its flag set.
  assign w_clr  = (w_nxt_state == SCAN) ? (N_CH'(1) << w_nxt_k) : '0;
  assign w_rd_I = {r_pp_I[w_nxt_k], r_pe_I[w_nxt_k]};
  assign w_rd_Q = {r_pp_Q[w_nxt_k], r_pe_Q[w_nxt_k]};
  always_comb begin
    w_hits = '0;
    for (int i = 0; i < N_CH; i++)
      w_hits = w_hits + HW'(eve_I[i] & r_pe_I[i] & ~w_clr[i]) + HW'(pol_I[i] & r_pp_I[i] & ~w_clr[i])
                      + HW'(eve_Q[i] & r_pe_Q[i] & ~w_clr[i]) + HW'(pol_Q[i] & r_pp_Q[i] & ~w_clr[i]);
  end
  assign w_sum = SW'(r_ovf) + SW'(w_hits);
  assign w_ovf = (w_sum > SW'({OVF_W{1'b1}})) ? {OVF_W{1'b1}} : w_sum[OVF_W-1:0];
  always_comb begin
    w_o_gray = '0;
    w_o_fs   = 1'b0;
    w_o_I    = '0;
    w_o_Q    = '0;
    w_o_busy = (w_nxt_state != IDLE);
    w_par_I  = r_par_I;
    w_par_Q  = r_par_Q;
    unique case (w_nxt_state)
      HEADER: begin
        w_o_fs  = 1'b1;
        w_o_I   = 2'b11;
        w_o_Q   = 2'b11;
        w_par_I = '0;
        w_par_Q = '0;
      end
      SCAN: begin
        w_o_gray = w_nxt_k ^ (w_nxt_k >> 1);
        w_o_I    = w_rd_I;
        w_o_Q    = w_rd_Q;
        w_par_I  = r_par_I ^ w_rd_I;
        w_par_Q  = r_par_Q ^ w_rd_Q;
      end
      PARITY: begin
        w_o_gray = r_slot_gray;
        w_o_I    = r_par_I;
        w_o_Q    = r_par_Q;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      r_pe_I       <= '0;
      r_pp_I       <= '0;
      r_pe_Q       <= '0;
      r_pp_Q       <= '0;
      r_slot_gray  <= '0;
      r_frame_sync <= 1'b0;
      r_ro_I       <= '0;
      r_ro_Q       <= '0;
      r_par_I      <= '0;
      r_par_Q      <= '0;
      r_ovf        <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_pe_I       <= (r_pe_I & ~w_clr) | eve_I;
      r_pp_I       <= (r_pp_I & ~w_clr) | pol_I;
      r_pe_Q       <= (r_pe_Q & ~w_clr) | eve_Q;
      r_pp_Q       <= (r_pp_Q & ~w_clr) | pol_Q;
      r_slot_gray  <= w_o_gray;
      r_frame_sync <= w_o_fs;
      r_ro_I       <= w_o_I;
      r_ro_Q       <= w_o_Q;
      r_par_I      <= w_par_I;
      r_par_Q      <= w_par_Q;
      r_ovf        <= w_ovf;
      r_busy       <= w_o_busy;
    end
  end
  assign slot_gray  = r_slot_gray;
  assign frame_sync = r_frame_sync;
  assign read_out_I = r_ro_I;
  assign read_out_Q = r_ro_Q;
  assign ovf_cnt    = r_ovf;
  assign busy       = r_busy;
endmodule

// File: tb/tb_ro_frame_sched.sv
// tb_ro_frame_sched: directed bench for ro_frame_sched with N_CH=4.
module tb_ro_frame_sched;
  logic       clk_master = 1'b0;
  logic       rstb = 1'b0, ro_en = 1'b0;
  logic [3:0] eve_I = '0, pol_I = '0, eve_Q = '0, pol_Q = '0;
  logic [1:0] slot_gray, read_out_I, read_out_Q;
  logic       frame_sync, busy;
  logic [7:0] ovf_cnt;
  logic [1:0] gtab [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
  int n_cmp = 0, n_bad = 0;
  ro_frame_sched #(.N_CH(4), .SLOT_W(2), .OVF_W(8)) dut (
    .clk_master(clk_master), .rstb(rstb), .ro_en(ro_en),
    .eve_I(eve_I), .pol_I(pol_I), .eve_Q(eve_Q), .pol_Q(pol_Q),
    .slot_gray(slot_gray), .frame_sync(frame_sync),
    .read_out_I(read_out_I), .read_out_Q(read_out_Q),
    .ovf_cnt(ovf_cnt), .busy(busy)
  );
  always #5 clk_master = ~clk_master;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_master);
    #1;
  endtask
  task automatic idle_outs(input string tg);
    chk({tg, "_busy"}, busy, 0);
    chk({tg, "_fs"}, frame_sync, 0);
    chk({tg, "_gray"}, slot_gray, 0);
    chk({tg, "_I"}, read_out_I, 0);
    chk({tg, "_Q"}, read_out_Q, 0);
  endtask
  // Next edge must enter the header; ei/eq hold the expected 2-bit value of slot k at [2k+:2].
  task automatic frame(input logic [7:0] ei, input logic [7:0] eq, input string tg);
`ifdef RO_PARITY_EN
    logic [1:0] pi = '0, pq = '0;
`endif
    tick();
    chk({tg, "_hdr_fs"}, frame_sync, 1);
    chk({tg, "_hdr_I"}, read_out_I, 2'b11);
    chk({tg, "_hdr_Q"}, read_out_Q, 2'b11);
    chk({tg, "_hdr_gray"}, slot_gray, 0);
    chk({tg, "_hdr_busy"}, busy, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("%s_s%0d_gray", tg, k), slot_gray, gtab[k]);
      chk($sformatf("%s_s%0d_fs", tg, k), frame_sync, 0);
      chk($sformatf("%s_s%0d_I", tg, k), read_out_I, ei[2*k+:2]);
      chk($sformatf("%s_s%0d_Q", tg, k), read_out_Q, eq[2*k+:2]);
`ifdef RO_PARITY_EN
      pi ^= ei[2*k+:2];
      pq ^= eq[2*k+:2];
`endif
    end
`ifdef RO_PARITY_EN
    tick();
    chk({tg, "_par_I"}, read_out_I, pi);
    chk({tg, "_par_Q"}, read_out_Q, pq);
    chk({tg, "_par_fs"}, frame_sync, 0);
    chk({tg, "_par_gray"}, slot_gray, 2);
`endif
  endtask
  initial begin
    #3;
    idle_outs("rst");
    chk("rst_ovf", ovf_cnt, 0);
    tick();
    rstb = 1'b1;
    eve_I = 4'b0100;
    tick();
    eve_I = '0;
    idle_outs("idle1");
    ro_en = 1'b1;
    frame(8'h10, 8'h00, "f1");
    frame(8'h00, 8'h00, "f2");
    chk("f2_ovf", ovf_cnt, 0);
    tick();
    chk("f3_hdr_fs", frame_sync, 1);
    eve_Q = 4'b0010;
    tick();
    chk("f3_s0_Q", read_out_Q, 0);
    tick();
    chk("f3_s1_Q", read_out_Q, 2'b01);
    chk("f3_s1_ovf", ovf_cnt, 0);
    eve_Q = '0;
    tick();
    tick();
`ifdef RO_PARITY_EN
    tick();
    chk("f3_par_Q", read_out_Q, 2'b01);
`endif
    frame(8'h00, 8'h04, "f4");
    chk("f4_ovf", ovf_cnt, 0);
    frame(8'h00, 8'h00, "f5");
    tick();
    tick();
    tick();
    ro_en = 1'b0;
    tick();
    tick();
    chk("drop_s3_gray", slot_gray, 2);
    chk("drop_s3_busy", busy, 1);
`ifdef RO_PARITY_EN
    tick();
`endif
    tick();
    idle_outs("drop_idle");
    tick();
    chk("drop_idle2_busy", busy, 0);
    eve_I = 4'b0001;
    tick();
    tick();
    tick();
    eve_I = '0;
    chk("ovf_3p", ovf_cnt, 2);
    eve_I = 4'b1111;
    tick();
    tick();
    eve_I = '0;
    chk("ovf_multi", ovf_cnt, 7);
    eve_I = 4'b0001;
    for (int i = 0; i < 300; i++) tick();
    chk("ovf_sat", ovf_cnt, 255);
    eve_I = 4'b1111;
    tick();
    eve_I = '0;
    tick();
    chk("ovf_hold", ovf_cnt, 255);
    ro_en = 1'b1;
    tick();
    chk("rs_hdr_fs", frame_sync, 1);
    tick();
    chk("rs_s0_I", read_out_I, 2'b01);
    tick();
    chk("rs_s1_I", read_out_I, 2'b01);
    #2 rstb = 1'b0;
    #1;
    idle_outs("async_rst");
    chk("async_rst_ovf", ovf_cnt, 0);
    ro_en = 1'b0;
    @(posedge clk_master);
    #1 rstb = 1'b1;
    eve_I = 4'b1001;
    pol_Q = 4'b0100;
    tick();
    eve_I = '0;
    pol_Q = '0;
    ro_en = 1'b1;
    frame(8'h41, 8'h20, "par");
    frame(8'h00, 8'h00, "last");
    chk("last_ovf", ovf_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ro_frame_sched.md
Name: ro_frame_sched

Overview:
- Readout scheduler for the shared read_out_I/read_out_Q bus of the cochlea channel array.
- Captures per-channel event and polarity-event pulses into sticky pending flags.
- Time-multiplexes those flags onto the 2-bit I and Q buses, one channel per slot, with a header slot each frame.
- Sits beside the channel wrappers on clk_master and publishes the Gray-coded slot index used for the time-division mux.

Parameters:
- N_CH, 16, number of channels scanned per frame (power of two, 2..64)
- SLOT_W, 4, slot index width, equal to log2(N_CH)
- OVF_W, 8, width of the saturating lost-event counter

Ports:
- clk_master  in  1  master clock, all logic on rising edge
- rstb  in  1  asynchronous active-low reset
- ro_en  in  1  readout enable
- eve_I  in  N_CH  per-channel I event pulse, synchronous to clk_master
- pol_I  in  N_CH  per-channel I polarity-event pulse
- eve_Q  in  N_CH  per-channel Q event pulse
- pol_Q  in  N_CH  per-channel Q polarity-event pulse
- slot_gray  out  SLOT_W  Gray code of the current channel slot
- frame_sync  out  1  high during the header slot
- read_out_I  out  2  bit0 = event, bit1 = polarity-event, for the current slot's channel
- read_out_Q  out  2  same as read_out_I, Q path
- ovf_cnt  out  OVF_W  lost-event count, saturating
- busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset (rstb low, asynchronous):
  - state = IDLE; all pending flags = 0.
  - slot_gray, read_out_I, read_out_Q, frame_sync, ovf_cnt, busy = 0.
- Pending flags: four N_CH-bit registers, pend_eve_I, pend_pol_I, pend_eve_Q, pend_pol_Q. Each bit is set on any rising edge where its input is 1.
- FSM states:
  - IDLE: outputs 0, pending flags held, no clearing. If ro_en = 1, go to HEADER.
  - HEADER: one cycle. frame_sync = 1, read_out_I = read_out_Q = 2'b11, slot_gray = 0. Go to SCAN with slot k = 0.
  - SCAN: N_CH cycles, k = 0..N_CH-1. slot_gray = k ^ (k >> 1).
    - After k = N_CH-1: go to HEADER if ro_en = 1, else IDLE.
    - ro_en falling mid-frame has no effect until the frame completes.
- All outputs are registered. They change on the same edge that enters the slot.
- Read-and-clear of slot k (on the edge entering SCAN slot k):
  - read_out_I <= {pend_pol_I[k], pend_eve_I[k]}, using the pre-edge flag values. read_out_Q is formed the same way from the Q flags.
  - The same edge clears those four flags of channel k.
  - Exception: if the input is 1 on that edge, the flag stays 1. The new event is reported next frame and does not count as overflow.
- Overflow: ovf_cnt increments by the number of flag-set attempts on that edge that hit an already-set flag not being read. It saturates at 2^OVF_W-1, clamped, no wrap.
- busy = 1 in HEADER and SCAN.
- Frame length is N_CH+1 cycles. slot_gray wraps from gray(N_CH-1) to 0 through the header.
- Reset asserted mid-frame: immediate return to reset values, and pending flags are lost.

Optional Feature:
- Macro: RO_PARITY_EN.
- Defined:
  - A PARITY slot follows slot N_CH-1, making the frame N_CH+2 cycles.
  - In PARITY, read_out_I[0] = XOR of all read_out_I[0] values emitted in the frame; read_out_I[1] likewise; Q path likewise.
  - frame_sync = 0 and slot_gray holds gray(N_CH-1) in PARITY.
  - The next-state decision described for the last slot moves to PARITY.
- Undefined: no PARITY state, and the frame is N_CH+1 cycles.

Test Plan:
- Reset then ro_en = 1, no events, N_CH=4 -> frame_sync pulses every 5 cycles; slot_gray sequence 0,1,3,2; read_out all 0 except 2'b11 in header; ovf_cnt = 0.
- Single eve_I[2] pulse while IDLE, then ro_en = 1 -> read_out_I = 2'b01 only in slot gray 3 of the first frame; 2'b00 in the second frame.
- eve_Q[1] high on the exact edge entering slot 1 with its flag already set -> reports 1 this frame and again 1 next frame; ovf_cnt unchanged.
- eve_I[0] pulsed 3 times in IDLE -> ovf_cnt = 2; 300 further pulses -> ovf_cnt = 255, stays 255.
- ro_en dropped during slot 1 -> frame completes through slot gray 2, then busy = 0 and outputs 0; reset pulse mid-SCAN -> all outputs 0 asynchronously, pending cleared.
- RO_PARITY_EN defined, eve_I on channels 0 and 3 plus pol_Q on channel 2 -> frame length 6; parity slot read_out_I = 2'b00, read_out_Q = 2'b10.
